// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped dual-lookup BTB with a background invalidation sweep.
// Define BTB_UPDATE_BYPASS_EN to forward an accepted update to same-cycle lookups.
module branch_target_buffer #(
    parameter int BTB_ENTRIES = 64,
    parameter int BTB_TAG_W   = 12,
    parameter int PC_W        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] IF_instr0_pc,
    input  logic [PC_W-1:0] IF_instr1_pc,
    output logic            IF_instr0_btb_hit,
    output logic            IF_instr1_btb_hit,
    output logic [PC_W-1:0] IF_instr0_btb_target,
    output logic [PC_W-1:0] IF_instr1_btb_target,
    input  logic            exe_btb_update_valid,
    input  logic [PC_W-1:0] exe_btb_update_pc,
    input  logic [PC_W-1:0] exe_btb_update_target,
    input  logic            btb_flush_req,
    output logic            btb_flush_busy
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                 state, state_nx;
    logic [IDX_W-1:0]       cnt, cnt_nx;
    logic [BTB_ENTRIES-1:0] valid;
    logic [BTB_TAG_W-1:0]   tags    [BTB_ENTRIES];
    logic [PC_W-1:0]        targets [BTB_ENTRIES];
    logic                   upd_en;
    logic [IDX_W-1:0]       upd_idx;
    logic [BTB_TAG_W-1:0]   upd_tag;
    logic [PC_W-1:0]        lk_pc   [2];
    logic [1:0]             hit;
    logic [PC_W-1:0]        tgt     [2];
    logic                   unused_pc_bits;

    assign btb_flush_busy = (state == SWEEP);
    assign upd_en  = exe_btb_update_valid && !btb_flush_busy && rst_n;
    assign upd_idx = exe_btb_update_pc[IDX_W+1:2];
    assign upd_tag = exe_btb_update_pc[IDX_W+BTB_TAG_W+1:IDX_W+2];
    assign unused_pc_bits = ^{IF_instr0_pc, IF_instr1_pc, exe_btb_update_pc};

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == IDLE) begin
            if (btb_flush_req) begin
                state_nx = SWEEP;
                cnt_nx   = '0;
            end
        end else begin
            // Hold the counter on the last index instead of wrapping.
            state_nx = (cnt == IDX_W'(BTB_ENTRIES - 1)) ? IDLE : SWEEP;
            cnt_nx   = (cnt == IDX_W'(BTB_ENTRIES - 1)) ? cnt : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == SWEEP)
                valid[cnt] <= 1'b0;
            else if (upd_en)
                valid[upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_en) begin
            tags[upd_idx]    <= upd_tag;
            targets[upd_idx] <= exe_btb_update_target;
        end
    end

    assign lk_pc[0] = IF_instr0_pc;
    assign lk_pc[1] = IF_instr1_pc;

    for (genvar g = 0; g < 2; g++) begin : g_slot
        logic [IDX_W-1:0]     idx;
        logic [BTB_TAG_W-1:0] tag;
        logic                 byp;
        assign idx = lk_pc[g][IDX_W+1:2];
        assign tag = lk_pc[g][IDX_W+BTB_TAG_W+1:IDX_W+2];
`ifdef BTB_UPDATE_BYPASS_EN
        assign byp = upd_en && (upd_idx == idx) && (upd_tag == tag);
`else
        assign byp = 1'b0;
`endif
        assign hit[g] = byp || (valid[idx] && (tags[idx] == tag) && !btb_flush_busy);
        assign tgt[g] = byp ? exe_btb_update_target : targets[idx];
    end

    assign IF_instr0_btb_hit    = hit[0];
    assign IF_instr1_btb_hit    = hit[1];
    assign IF_instr0_btb_target = tgt[0];
    assign IF_instr1_btb_target = tgt[1];
endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter BTB_ENTRIES, default 64, meaning number of direct-mapped entries (power of two, >=4).
REQ-002 SHALL have parameter BTB_TAG_W, default 12, meaning stored tag width in bits.
REQ-003 SHALL have clk  input  1  the single clock; all state updates on posedge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have IF_instr0_pc  input  pc_t  lookup PC, slot 0.
REQ-006 SHALL have IF_instr1_pc  input  pc_t  lookup PC, slot 1.
REQ-007 SHALL have IF_instr0_btb_hit  output  1  slot-0 PC present in the table (feeds the bimodal predictor).
REQ-008 SHALL have IF_instr1_btb_hit  output  1  slot-1 PC present in the table.
REQ-009 SHALL have IF_instr0_btb_target  output  pc_t  predicted target, slot 0.
REQ-010 SHALL have IF_instr1_btb_target  output  pc_t  predicted target, slot 1.
REQ-011 SHALL have exe_btb_update_valid  input  1  EXE resolved a taken control transfer this cycle.
REQ-012 SHALL have exe_btb_update_pc  input  pc_t  PC of the resolved branch.
REQ-013 SHALL have exe_btb_update_target  input  pc_t  resolved target address.
REQ-014 SHALL have btb_flush_req  input  1  single-cycle pulse requesting invalidation of all entries.
REQ-015 SHALL have btb_flush_busy  output  1  invalidation sweep in progress.

Function
REQ-016 Index SHALL be pc[IDX_W+1:2], IDX_W=log2(BTB_ENTRIES); tag SHALL be pc[IDX_W+BTB_TAG_W+1:IDX_W+2].
REQ-017 Each entry SHALL hold valid (1b), tag (BTB_TAG_W), target (pc_t width; bits [1:0] stored as written).
REQ-018 Lookup SHALL be combinational from registered state: hit = valid & tag match & !btb_flush_busy; target = entry target regardless of hit.
REQ-019 Both lookup slots SHALL be independent; identical PCs SHALL return identical results.
REQ-020 Update with exe_btb_update_valid=1 and btb_flush_busy=0 SHALL write valid=1, tag, target into the indexed entry on the next posedge, overwriting any previous occupant.
REQ-021 Sweep FSM SHALL have states IDLE and SWEEP; IDLE->SWEEP on btb_flush_req=1, counter loaded with 0.
REQ-022 In SWEEP, valid[counter] SHALL clear each cycle and counter SHALL increment; SWEEP->IDLE after index BTB_ENTRIES-1 is cleared (exactly BTB_ENTRIES cycles of busy).
REQ-023 btb_flush_busy SHALL be 1 exactly while state==SWEEP (registered, asserts the cycle after the request).
REQ-024 btb_flush_req while in SWEEP SHALL be ignored (no restart).
REQ-025 Update and btb_flush_req in the same cycle in IDLE: update SHALL be written, then swept; updates during SWEEP SHALL be dropped.
REQ-026 Counter SHALL be IDX_W bits and SHALL NOT wrap past BTB_ENTRIES-1 in SWEEP.

Reset
REQ-027 On rst_n=0, all valid bits SHALL clear, FSM SHALL enter IDLE, counter SHALL be 0; tags/targets need not be reset.
REQ-028 During and after reset, IF_instr0_btb_hit=IF_instr1_btb_hit=0 and btb_flush_busy=0; reset mid-sweep SHALL abort the sweep.

Configuration
REQ-029 Macro BTB_UPDATE_BYPASS_EN SHALL control same-cycle forwarding.
REQ-030 With BTB_UPDATE_BYPASS_EN defined, a lookup whose index and tag equal an active (accepted) update SHALL report hit=1 and target=exe_btb_update_target in that same cycle.
REQ-031 Without BTB_UPDATE_BYPASS_EN, the update SHALL become visible only from the cycle after the write edge.

Verification
REQ-032 Reset, then lookup 0x0000_1000 on both slots -> both hits 0, busy 0.
REQ-033 Update pc=0x0000_1000 target=0x0000_2000; next cycle lookup 0x0000_1000 -> hit=1, target=0x0000_2000; lookup 0x0001_1000 (same index, other tag) -> hit=0.
REQ-034 Update pc=0x0000_1000 target=0x0000_2000 then pc=0x0000_1000 target=0x0000_3000 -> target 0x0000_3000 (overwrite).
REQ-035 Fill 4 entries, pulse btb_flush_req -> busy high for exactly 64 cycles, hits 0 throughout and after; update issued mid-sweep -> not present afterward.
REQ-036 Same-cycle update pc=0x0000_1040 and lookup 0x0000_1040 -> hit=1 that cycle with BTB_UPDATE_BYPASS_EN, hit=0 that cycle and 1 next cycle without.
REQ-037 Assert rst_n=0 at sweep cycle 10 -> busy=0 and all hits 0 immediately; after release, updates accepted the first cycle.
